// File: rtl/prefix_adder_pipe.sv
// Three-stage pipelined Brent-Kung prefix adder/subtractor with valid/ready handshakes.
// Optional result flags (out_zero, out_neg, out_ovf) are enabled by defining PREFIX_ADDER_FLAGS_EN.
module prefix_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int GROUPSIZE = 4,
  parameter int TAGW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_op,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAGW-1:0]  out_tag
`ifdef PREFIX_ADDER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
`endif
);

  localparam int NG   = WIDTH / GROUPSIZE;
  localparam int LOGN = $clog2(NG);

  logic             en1_s, en2_s, en3_s;
  logic             v1_r, v2_r;
  logic [WIDTH-1:0] b_eff_s;
  logic             c0_s;
  logic [NG-1:0]    grp_g_s, grp_p_s;
  logic [WIDTH-1:0] a1_r, b1_r;
  logic             c01_r;
  logic [TAGW-1:0]  tag1_r;
  logic [NG-1:0]    g1_r, p1_r;
  logic [NG:0]      cy_s;
  logic [WIDTH-1:0] a2_r, b2_r;
  logic [NG:0]      cy2_r;
  logic [TAGW-1:0]  tag2_r;
  logic [WIDTH-1:0] sum3_s;

  // Stage enables: a stage loads when empty or when its successor moves on, so bubbles collapse.
  always_comb begin
    en3_s    = !out_valid || out_ready;
    en2_s    = !v2_r || en3_s;
    en1_s    = !v1_r || en2_s;
    in_ready = en1_s;
  end

  // S1: effective operands and per-group generate/propagate.
  always_comb begin
    logic gc, pc;
    b_eff_s = in_b ^ {WIDTH{in_op[1]}};
    c0_s    = in_op[0] ? in_cin : in_op[1];
    grp_g_s = '0;
    grp_p_s = '0;
    for (int k = 0; k < NG; k++) begin
      gc = 1'b0;
      pc = 1'b1;
      for (int j = 0; j < GROUPSIZE; j++) begin
        gc = (in_a[k*GROUPSIZE+j] & b_eff_s[k*GROUPSIZE+j]) |
             ((in_a[k*GROUPSIZE+j] ^ b_eff_s[k*GROUPSIZE+j]) & gc);
        pc = pc & (in_a[k*GROUPSIZE+j] ^ b_eff_s[k*GROUPSIZE+j]);
      end
      grp_g_s[k] = gc;
      grp_p_s[k] = pc;
    end
  end

  // S2: Brent-Kung up-sweep then down-sweep; entry i ends up covering groups [i:0].
  always_comb begin
    logic [NG-1:0] gv, pv;
    gv = g1_r;
    pv = p1_r;
    for (int l = 0; l < LOGN; l++) begin
      for (int i = (32'sd2 << l) - 32'sd1; i < NG; i += (32'sd2 << l)) begin
        gv[i] = gv[i] | (pv[i] & gv[i-(32'sd1 << l)]);
        pv[i] = pv[i] & pv[i-(32'sd1 << l)];
      end
    end
    for (int l = LOGN - 2; l >= 0; l--) begin
      for (int i = (32'sd3 << l) - 32'sd1; i < NG; i += (32'sd2 << l)) begin
        gv[i] = gv[i] | (pv[i] & gv[i-(32'sd1 << l)]);
        pv[i] = pv[i] & pv[i-(32'sd1 << l)];
      end
    end
    cy_s[0] = c01_r;
    for (int k = 1; k <= NG; k++) begin
      cy_s[k] = gv[k-1] | (pv[k-1] & c01_r);
    end
  end

  // S3: ripple each group from its registered carry-in.
  always_comb begin
    logic c;
    sum3_s = '0;
    for (int k = 0; k < NG; k++) begin
      c = cy2_r[k];
      for (int j = 0; j < GROUPSIZE; j++) begin
        sum3_s[k*GROUPSIZE+j] = a2_r[k*GROUPSIZE+j] ^ b2_r[k*GROUPSIZE+j] ^ c;
        c = (a2_r[k*GROUPSIZE+j] & b2_r[k*GROUPSIZE+j]) |
            ((a2_r[k*GROUPSIZE+j] ^ b2_r[k*GROUPSIZE+j]) & c);
      end
    end
  end

  // Pipeline registers; data only moves with a valid occupant so held outputs stay stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      out_valid <= 1'b0;
      a1_r      <= '0;
      b1_r      <= '0;
      c01_r     <= 1'b0;
      tag1_r    <= '0;
      g1_r      <= '0;
      p1_r      <= '0;
      a2_r      <= '0;
      b2_r      <= '0;
      cy2_r     <= '0;
      tag2_r    <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_tag   <= '0;
`ifdef PREFIX_ADDER_FLAGS_EN
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      out_ovf   <= 1'b0;
`endif
    end else begin
      if (en1_s) v1_r <= in_valid;
      if (en2_s) v2_r <= v1_r;
      if (en3_s) out_valid <= v2_r;
      if (en1_s && in_valid) begin
        a1_r   <= in_a;
        b1_r   <= b_eff_s;
        c01_r  <= c0_s;
        tag1_r <= in_tag;
        g1_r   <= grp_g_s;
        p1_r   <= grp_p_s;
      end
      if (en2_s && v1_r) begin
        a2_r   <= a1_r;
        b2_r   <= b1_r;
        cy2_r  <= cy_s;
        tag2_r <= tag1_r;
      end
      if (en3_s && v2_r) begin
        out_sum  <= sum3_s;
        out_cout <= cy2_r[NG];
        out_tag  <= tag2_r;
`ifdef PREFIX_ADDER_FLAGS_EN
        out_zero <= (sum3_s == '0);
        out_neg  <= sum3_s[WIDTH-1];
        out_ovf  <= (a2_r[WIDTH-1] == b2_r[WIDTH-1]) && (sum3_s[WIDTH-1] != a2_r[WIDTH-1]);
`endif
      end
    end
  end

endmodule
